hazard_ctrl: RTL

//  Pipeline hazard controller for the 5-stage RV32 core. Generates the select lines for the

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding selects, load-use /
// multi-cycle stalls, taken-branch redirects and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REDIRECT_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_busy,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, BUSY, REDIRECT} state_t;

    localparam int RW = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES) : 1;
    localparam logic [RW-1:0]    RONE = 1;
    localparam logic [CNT_W-1:0] CONE = 1;

    state_t        state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          flush_acc;
    logic          load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a_sel = rst ? 2'b00 : fwd_sel(ex_rs1);
        fwd_b_sel = rst ? 2'b00 : fwd_sel(ex_rs2);
    end

    assign load_use = id_valid && ex_memread && ex_rd != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    always_comb begin
        pc_sel       = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        state_nxt    = state;
        rcnt_nxt     = rcnt;
        flush_acc    = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            case (state)
                REDIRECT: begin
                    // EX only holds bubbles here, so branch/busy inputs are meaningless
                    ifid_flush = 1'b1;
                    if (rcnt != '0) rcnt_nxt = rcnt - RONE;
                    if (rcnt <= RONE) state_nxt = RUN;
                end
                default: begin
                    // BUSY with ex_busy low falls through to the RUN rules in the same cycle
                    if (ex_busy) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        state_nxt    = BUSY;
                    end else if (ex_br_taken) begin
                        pc_sel      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_acc   = 1'b1;
                        if (REDIRECT_CYCLES > 1) begin
                            state_nxt = REDIRECT;
                            rcnt_nxt  = RW'(REDIRECT_CYCLES - 1);
                        end else begin
                            state_nxt = RUN;
                        end
                    end else begin
                        state_nxt = RUN;
                        if (load_use) begin
                            pc_write    = 1'b0;
                            ifid_write  = 1'b0;
                            idex_bubble = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            rcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CONE;
            if (flush_acc && flush_cnt != '1) flush_cnt <= flush_cnt + CONE;
        end
    end
endmodule
